easy_serial_in: RTL and testbench

Receiving end of the alarm's one-wire-plus-strobe serial link. Captures 4-bit state messages sent by the transmit side's `state_send` strobe and `state_out` data line, and presents each accepted message on a parallel bus with a one-cycle valid pulse. Optionally requires two identical consecutive frames before accepting one. Flags `link_lost` when no complete frame arrives within a timeout, so the main module can treat a cut or stuck line as an alarm condition.

---
 rtl/easy_serial_in_pkg.sv | 19 +
 rtl/easy_serial_in_link_watchdog.sv | 54 +++++
 rtl/easy_serial_in.sv | 111 +++++++++++
 tb/tb_easy_serial_in.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/easy_serial_in_pkg.sv
// easy_serial_in_pkg
//   Shared definitions for the alarm serial link (receive side).
//   MSG_W      : width of one state message
//   FRAME_BITS : number of data bits following the start strobe
//   state_t    : receive FSM states
package easy_serial_in_pkg;

    localparam int unsigned MSG_W      = 4;
    localparam int unsigned FRAME_BITS = 4;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    typedef logic [MSG_W-1:0] msg_t;

endpackage

// File: rtl/easy_serial_in_link_watchdog.sv
// link_watchdog
//   Saturating idle counter for the serial link.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   en      : count/update enable; everything holds when low
//   clear   : restart the count (a complete frame arrived)
//   expired : registered flag, high while the count sits at TIMEOUT
module link_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (en) begin
            if (clear) begin
                cnt_d     = '0;
                expired_d = 1'b0;
            end else begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Flag follows the count one cycle later, but drops in the
                // same cycle as the clear.
                expired_d = (cnt_q == CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/easy_serial_in.sv
// easy_serial_in
//   Receiver for the alarm's strobe + one-wire serial link. A frame is a
//   one-cycle state_send strobe followed by 4 data bits on state_out, LSB
//   first. Complete frames are optionally confirmed (two identical in a row)
//   before being presented on msg with a one-cycle msg_valid pulse.
//   CLK        : system clock
//   nRST       : synchronous active-low reset
//   EN         : enable; low forces IDLE and freezes the rest
//   state_send : frame start strobe
//   state_out  : serial data line
//   msg        : last accepted message
//   msg_valid  : one-cycle pulse when msg is written
//   link_lost  : high while no complete frame arrived within TIMEOUT cycles
module easy_serial_in
    import easy_serial_in_pkg::*;
#(
    parameter int unsigned CONFIRM = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             EN,
    input  logic             state_send,
    input  logic             state_out,
    output logic [MSG_W-1:0] msg,
    output logic             msg_valid,
    output logic             link_lost
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    state_t                state_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [FRAME_BITS-2:0] shift_q;
    msg_t                  cand_q;
    logic                  cand_v_q;
    msg_t                  msg_q;
    logic                  msg_valid_q;

    msg_t                  frame_d;
    logic                  frame_done;

    // The last bit is taken straight from the line, so the frame is usable
    // in the cycle it completes.
    assign frame_d    = {state_out, shift_q};
    assign frame_done = EN && (state_q == S_RECV) && !state_send
                        && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cand_q      <= '0;
            cand_v_q    <= 1'b0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            msg_valid_q <= 1'b0;
            if (!EN) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (state_send) begin
                            state_q   <= S_RECV;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_RECV: begin
                        if (state_send) begin
                            // Strobe mid-frame restarts reception.
                            bit_cnt_q <= '0;
                        end else if (bit_cnt_q == LAST_BIT) begin
                            state_q   <= S_IDLE;
                            bit_cnt_q <= '0;
                            cand_q    <= frame_d;
                            cand_v_q  <= 1'b1;
                            if ((CONFIRM == 0) || (cand_v_q && (cand_q == frame_d))) begin
                                msg_q       <= frame_d;
                                msg_valid_q <= 1'b1;
                            end
                        end else begin
                            shift_q[bit_cnt_q] <= state_out;
                            bit_cnt_q          <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        bit_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    link_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (CLK),
        .rst_n  (nRST),
        .en     (EN),
        .clear  (frame_done),
        .expired(link_lost)
    );

    assign msg       = msg_q;
    assign msg_valid = msg_valid_q;

endmodule

// File: tb/tb_easy_serial_in.sv
module tb_easy_serial_in;

    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       EN = 1'b0;
    logic       state_send = 1'b0;
    logic       state_out = 1'b0;
    logic [3:0] msg0, msg1;
    logic       val0, val1, ll0, ll1;

    always #5 CLK = ~CLK;

    easy_serial_in #(.CONFIRM(0), .TIMEOUT(TO)) dut0 (
        .CLK(CLK), .nRST(nRST), .EN(EN), .state_send(state_send),
        .state_out(state_out), .msg(msg0), .msg_valid(val0), .link_lost(ll0)
    );

    easy_serial_in #(.CONFIRM(1), .TIMEOUT(TO)) dut1 (
        .CLK(CLK), .nRST(nRST), .EN(EN), .state_send(state_send),
        .state_out(state_out), .msg(msg1), .msg_valid(val1), .link_lost(ll1)
    );

    // One cycle of stimulus; done marks the cycle whose edge completes a
    // full frame carrying fval.
    typedef struct {
        bit       rst;
        bit       en;
        bit       send;
        bit       data;
        bit       done;
        bit [3:0] fval;
    } cyc_t;

    cyc_t q[$];

    int total = 0;
    int bad   = 0;
    int n;

    // Reference state: per instance (0: no confirm, 1: confirm)
    bit [3:0] e_msg[2];
    bit       e_val[2];
    bit [3:0] cand[2];
    bit       cand_v[2];
    int       since;   // enabled cycles since last complete frame / reset

    function automatic void push(bit rst, bit en, bit send, bit data, bit done, bit [3:0] fval);
        cyc_t c;
        c.rst = rst; c.en = en; c.send = send; c.data = data; c.done = done; c.fval = fval;
        q.push_back(c);
    endfunction

    function automatic void push_frame(bit [3:0] v);
        push(0, 1, 1, 1'($urandom % 2), 0, 0);
        for (int b = 0; b < 4; b++) push(0, 1, 0, v[b], b == 3, v);
    endfunction

    function automatic void push_idle(int cnt, bit en);
        for (int i = 0; i < cnt; i++) push(0, en, 0, 1'($urandom % 2), 0, 0);
    endfunction

    function automatic logic [11:0] obs();
        return {msg0, val0, ll0, msg1, val1, ll1};
    endfunction

    function automatic logic [11:0] expv();
        bit ll;
        ll = (since > TO);
        return {e_msg[0], e_val[0], ll, e_msg[1], e_val[1], ll};
    endfunction

    task automatic step(input cyc_t c);
        bit acc;
        nRST = !c.rst; EN = c.en; state_send = c.send; state_out = c.data;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) e_val[i] = 0;
        if (c.rst) begin
            since = 0;
            for (int i = 0; i < 2; i++) begin
                e_msg[i] = 0; cand[i] = 0; cand_v[i] = 0;
            end
        end else begin
            if (c.en && since < 1000) since++;
            if (c.done) begin
                since = 0;
                for (int i = 0; i < 2; i++) begin
                    acc = (i == 0) || (cand_v[i] && cand[i] == c.fval);
                    cand[i] = c.fval;
                    cand_v[i] = 1;
                    if (acc) begin
                        e_msg[i] = c.fval;
                        e_val[i] = 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        push(1, 0, 0, 0, 0, 0);
        push(1, 1, 1, 1, 0, 0);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL reset cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_single();
        push_frame(4'hD);
        push_idle(2, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL single cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_confirm();
        push_frame(4'h5); push_idle(1, 1);
        push_frame(4'h5); push_idle(2, 1);
        push_frame(4'h9); push_idle(1, 1);
        push_frame(4'h5); push_idle(1, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL confirm cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_resync();
        // strobe, 2 bits, strobe, full 0xA
        push(0, 1, 1, 0, 0, 0);
        push(0, 1, 0, 1, 0, 0);
        push(0, 1, 0, 1, 0, 0);
        push(0, 1, 1, 1, 0, 0);
        for (int b = 0; b < 4; b++) push(0, 1, 0, b == 1 || b == 3, b == 3, 4'hA);
        push_idle(1, 1);
        // strobe on the bit-3 cycle, then full 0xA again
        push(0, 1, 1, 0, 0, 0);
        for (int b = 0; b < 3; b++) push(0, 1, 0, 1, 0, 0);
        push(0, 1, 1, 1, 0, 0);
        for (int b = 0; b < 4; b++) push(0, 1, 0, b == 1 || b == 3, b == 3, 4'hA);
        push_idle(1, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL resync cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        push_frame(4'h6); push_frame(4'h6); push_frame(4'hE); push_frame(4'hE);
        push_idle(1, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL b2b cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_timeout();
        push(1, 1, 0, 0, 0, 0);
        push_idle(TO + 3, 1);
        push_frame(4'h2);
        push_idle(TO + 3, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL timeout cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_en_drop();
        push(1, 1, 0, 0, 0, 0);
        push_idle(TO - 1, 1);
        push(0, 1, 1, 0, 0, 0);
        push(0, 1, 0, 1, 0, 0);
        push(0, 1, 0, 1, 0, 0);
        push(0, 0, 0, 1, 0, 0);
        push(0, 0, 0, 1, 0, 0);
        push(0, 0, 1, 0, 0, 0);
        push_idle(3, 1);
        push_idle(2, 0);
        push_frame(4'h3); push_frame(4'h3);
        push_idle(1, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL en_drop cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_midframe();
        push_frame(4'h7); push_frame(4'h7);
        push(0, 1, 1, 0, 0, 0);
        push(0, 1, 0, 1, 0, 0);
        push(0, 1, 0, 1, 0, 0);
        push(1, 1, 0, 1, 0, 0);
        push_frame(4'h7); push_idle(1, 1);
        push_frame(4'h7); push_idle(1, 1);
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL rst_mid cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        bit [3:0] v;
        bit [4:0] m;
        for (int k = 0; k < 60; k++) begin
            v = 4'($urandom_range(0, 3)) ^ 4'hC;
            for (int j = 0; j < 5; j++) m[j] = ($urandom % 8) != 0;
            push(0, m[0], 1, 1'($urandom % 2), 0, 0);
            for (int b = 0; b < 4; b++) push(0, m[b+1], 0, v[b], (b == 3) && (&m), v);
            for (int g = $urandom_range(0, 12); g > 0; g--)
                push(0, ($urandom % 4) != 0, 0, 1'($urandom % 2), 0, 0);
        end
        n = 0;
        while (q.size() > 0) begin
            step(q.pop_front()); n++; total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", n, obs(), expv());
            end
        end
    endtask

    initial begin
        since = 0;
        for (int i = 0; i < 2; i++) begin
            e_msg[i] = 0; e_val[i] = 0; cand[i] = 0; cand_v[i] = 0;
        end
        #2;
        test_reset();
        test_single();
        test_confirm();
        test_resync();
        test_back_to_back();
        test_timeout();
        test_en_drop();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
